// File: rtl/ysyx_22040931_fetch_unit_pkg.sv
// ============================================================================
// ysyx_22040931_fetch_unit_pkg: shared counter encodings and fetch defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22040931_fetch_unit_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int unsigned PC_STEP          = 4;
  localparam int unsigned INST_ALIGN_W     = 2;
  localparam int unsigned FQ_META_W        = 1;
  // Headroom so back-to-back redirects never overflow the drop counter.
  localparam int unsigned DROP_EXTRA_W     = 3;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      default: n = taken ? CTR_ST  : CTR_WT;
    endcase
    return n;
  endfunction

  function automatic logic ctr_taken(input ctr_e c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040931_btb.sv
// ============================================================================
// ysyx_22040931_btb: direct-mapped BTB with 2-bit counters, comb lookup port
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22040931_btb
  import ysyx_22040931_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            lookup_taken_o,
  output logic [PC_W-1:0] lookup_tgt_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - INST_ALIGN_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [PC_W-1:0]        tgt_q [BTB_ENTRIES];
  ctr_e                   ctr_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             lk_hit;
  logic             up_hit;
  logic             unused_lsbs;

  assign lk_idx      = lookup_pc_i[IDX_W+INST_ALIGN_W-1:INST_ALIGN_W];
  assign lk_tag      = lookup_pc_i[PC_W-1:IDX_W+INST_ALIGN_W];
  assign up_idx      = upd_pc_i[IDX_W+INST_ALIGN_W-1:INST_ALIGN_W];
  assign up_tag      = upd_pc_i[PC_W-1:IDX_W+INST_ALIGN_W];
  assign unused_lsbs = ^{lookup_pc_i[INST_ALIGN_W-1:0], upd_pc_i[INST_ALIGN_W-1:0]};

  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign lookup_taken_o = lk_hit && ctr_taken(ctr_q[lk_idx]);
  assign lookup_tgt_o   = tgt_q[lk_idx];

  // Lookup is combinational off the registered arrays, so a same-cycle update sees old data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
        if (upd_taken_i) begin
          tgt_q[up_idx] <= upd_target_i;
        end
      end else begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target_i;
        ctr_q[up_idx]   <= upd_taken_i ? CTR_WT : CTR_WNT;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040931_fetch_unit.sv
// ============================================================================
// ysyx_22040931_fetch_unit: PC gen, BTB prediction, imem issue and fetch queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22040931_fetch_unit
  import ysyx_22040931_fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     INST_W      = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter int unsigned     FQ_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_pred_taken,
  output logic [PC_W-1:0]   out_pred_tgt
);

  localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = CNT_W + DROP_EXTRA_W;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d, outst_q, outst_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [PC_W-1:0]      fq_pc_q   [FQ_DEPTH];
  logic [PC_W-1:0]      fq_tgt_q  [FQ_DEPTH];
  logic [INST_W-1:0]    fq_inst_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0]  fq_pred_q;
  logic [FQ_DEPTH-1:0]  fq_dv_q;

  logic            pred_taken;
  logic [PC_W-1:0] pred_tgt;
  logic [PC_W-1:0] next_pc;
  logic            push, pop, fill, rsp_drop, rsp_consumed;

  ysyx_22040931_btb #(
    .PC_W        (PC_W),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clock          (clock),
    .reset          (reset),
    .lookup_pc_i    (pc_q),
    .lookup_taken_o (pred_taken),
    .lookup_tgt_o   (pred_tgt),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .upd_target_i   (upd_target)
  );

  assign next_pc        = pred_taken ? pred_tgt : pc_q + PC_W'(PC_STEP);
  assign imem_req_valid = !reset && !stall && !redirect && (count_q < CNT_W'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;

  assign push         = imem_req_valid && imem_req_ready;
  assign rsp_drop     = imem_rsp_valid && (drop_q != '0);
  assign fill         = imem_rsp_valid && (drop_q == '0) && (outst_q != '0);
  assign rsp_consumed = imem_rsp_valid && ((drop_q != '0) || (outst_q != '0));

  assign out_valid      = (count_q != '0) && fq_dv_q[head_q];
  assign pop            = out_valid && out_ready && !redirect;
  assign out_pc         = out_valid ? fq_pc_q[head_q]   : '0;
  assign out_inst       = out_valid ? fq_inst_q[head_q] : '0;
  assign out_pred_taken = out_valid && fq_pred_q[head_q];
  assign out_pred_tgt   = out_valid ? fq_tgt_q[head_q]  : '0;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (redirect) begin
      // Everything still in flight, minus a response retiring this cycle, becomes stale.
      pc_d    = redirect_pc;
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      count_d = '0;
      outst_d = '0;
      drop_d  = drop_q + DROP_W'(outst_q) - DROP_W'(rsp_consumed);
    end else begin
      if (push) begin
        pc_d   = next_pc;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (fill) begin
        fill_d = fill_q + PTR_W'(1);
      end
      if (rsp_drop) begin
        drop_d = drop_q - DROP_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      outst_d = outst_q + CNT_W'(push) - CNT_W'(fill);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fq_pred_q <= '0;
      fq_dv_q   <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        fq_pc_q[i]   <= '0;
        fq_tgt_q[i]  <= '0;
        fq_inst_q[i] <= '0;
      end
    end else if (redirect) begin
      fq_dv_q <= '0;
    end else begin
      if (push) begin
        fq_pc_q[tail_q]   <= pc_q;
        fq_pred_q[tail_q] <= pred_taken;
        fq_tgt_q[tail_q]  <= next_pc;
        fq_dv_q[tail_q]   <= 1'b0;
      end
      if (fill) begin
        fq_inst_q[fill_q] <= imem_rsp_data;
        fq_dv_q[fill_q]   <= 1'b1;
      end
      if (pop) begin
        fq_dv_q[head_q] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
